// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for synchronous_fifo: prefetches into a small ring buffer
// and presents words on a valid/ready stream. Optional FIFO_READER_COUNT_EN adds word_count.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [31:0]           word_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_L  = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] buffer [BUF_DEPTH];
  logic [OCC_W-1:0]      occ;
  logic                  inflight;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [OCC_W:0]        pending;
  logic                  capture;
  logic                  pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue counts the in-flight word as occupied so the returning data always has a slot.
  always_comb begin
    pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    fifo_r_en = rst_n && !fifo_empty && !flush && (pending < DEPTH_L);
    m_valid   = (occ != '0) && !flush;
    pop       = m_valid && m_ready;
    capture   = inflight && !flush;
    busy      = (occ != '0) || inflight;
    m_data    = buffer[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buffer[i] <= '0;
      end
    end else if (flush) begin
      occ      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (capture) begin
        buffer[wr_ptr] <= fifo_data_out;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule
